// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, single-entry delivery register, branch redirect.
// Optional macro IF_HALT_DETECT_EN: stop fetching after an hlt (opcode 5'b11111) is accepted downstream.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        of_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, DELIVER, DRAIN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        halt_q, halt_d;
    logic [31:0] target;
    logic        is_hlt;

    assign target = {branch_target[31:2], 2'b00};

`ifdef IF_HALT_DETECT_EN
    assign is_hlt = (instr_q[31:27] == 5'b11111);
`else
    assign is_hlt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if_pc_d = if_pc_q;
        instr_d = instr_q;
        halt_d  = halt_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    // A response arriving with the redirect is stale; without one we must drain.
                    pc_d    = target;
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (of_ready) begin
                    valid_d = 1'b0;
                    if (is_hlt) begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (branch_taken) pc_d = target;
                if (imem_ack) state_d = FETCH;
            end
            HALTED: begin
            end
            default: state_d = FETCH;
        endcase
        req_d  = (state_d == FETCH) || (state_d == DRAIN);
        // While draining, the old address stays on the bus until the memory acks it.
        addr_d = (state_d == DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            if_pc_q <= 32'h0;
            instr_q <= 32'h0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
            halt_q  <= halt_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign if_valid       = valid_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = instr_q;
    assign halted         = halt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        of_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    // Model: what the outside world should see, tracked per transaction.
    logic        m_held;      // an instruction sits at the output waiting for acceptance
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_next_pc;   // address of the next fetch that will be delivered
    logic        m_stale;     // the live request was overtaken by a redirect
    logic [31:0] m_stale_addr;
    logic        m_halted;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .of_ready(of_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic m_req();
        return !m_held && !m_halted;
    endfunction

    function automatic logic [31:0] m_addr();
        return m_stale ? m_stale_addr : m_next_pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_pc = 0; m_instr = 0; m_next_pc = RST_PC;
        m_stale = 0; m_stale_addr = 0; m_halted = 0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] rd, input logic br,
                              input logic [31:0] tgt, input logic rdy);
        logic [31:0] al;
        al = tgt & 32'hFFFF_FFFC;
        if (m_halted) begin
        end else if (m_held) begin
            if (br) begin
                m_held = 0; m_next_pc = al;
            end else if (rdy) begin
                m_held = 0;
`ifdef IF_HALT_DETECT_EN
                if (m_instr[31:27] == 5'b11111) m_halted = 1;
`endif
            end
        end else if (ack) begin
            if (m_stale || br) begin
                m_stale = 0;
                if (br) m_next_pc = al;
            end else begin
                m_held = 1; m_pc = m_next_pc; m_instr = rd; m_next_pc = m_next_pc + 32'd4;
            end
        end else if (br) begin
            if (!m_stale) begin
                m_stale = 1; m_stale_addr = m_next_pc;
            end
            m_next_pc = al;
        end
    endtask

    task automatic check_outputs();
        check("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        if (m_req()) check("imem_addr", imem_addr, m_addr());
        check("if_valid", {31'h0, if_valid}, {31'h0, m_held});
        if (m_held) begin
            check("if_pc", if_pc, m_pc);
            check("if_instruction", if_instruction, m_instr);
        end
        check("halted", {31'h0, halted}, {31'h0, m_halted});
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic cycle(input logic ack, input logic [31:0] rd, input logic br,
                         input logic [31:0] tgt, input logic rdy);
        logic a;
        a = ack && m_req();
        imem_ack = a; imem_rdata = rd; branch_taken = br; branch_target = tgt; of_ready = rdy;
        @(posedge clk);
        model_step(a, rd, br, tgt, rdy);
        #1;
        imem_ack = 0; branch_taken = 0; of_ready = 0;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1; imem_ack = 0; branch_taken = 0; of_ready = 0;
        imem_rdata = 0; branch_target = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst if_valid", {31'h0, if_valid}, 32'h0);
        check("rst if_pc", if_pc, 32'h0);
        check("rst if_instruction", if_instruction, 32'h0);
        check("rst halted", {31'h0, halted}, 32'h0);
        reset = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] tg;
        logic [31:0] pc_hold;

        do_reset();

        // Sequential fetch from RESET_PC, ack one cycle after each request, always ready.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0);
            check("seq addr", imem_addr, RST_PC + 32'(4 * i));
            rd = 32'hA000_0000 + 32'(i);
            cycle(1, rd, 0, 0, 0);
            check("seq if_pc", if_pc, RST_PC + 32'(4 * i));
            check("seq if_instruction", if_instruction, rd);
            cycle(0, 0, 0, 0, 1);
        end

        // Back-pressure: held output stays stable with no request.
        cycle(1, 32'h1234_5678, 0, 0, 0);
        pc_hold = if_pc;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            check("stall instr", if_instruction, 32'h1234_5678);
            check("stall pc", if_pc, pc_hold);
            check("stall req", {31'h0, imem_req}, 32'h0);
        end
        cycle(0, 0, 0, 0, 1);
        check("after stall addr", imem_addr, pc_hold + 32'd4);

        // Redirect to 0x200 from DELIVER, then redirect during the pending 0x200 request.
        cycle(1, 32'h0000_0011, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0200, 0);
        check("redir addr", imem_addr, 32'h0000_0200);
        cycle(0, 0, 1, 32'h0000_0403, 0);
        check("drain addr", imem_addr, 32'h0000_0200);
        cycle(0, 0, 0, 0, 0);
        check("drain addr hold", imem_addr, 32'h0000_0200);
        cycle(1, 32'hDEAD_BEEF, 0, 0, 0);
        check("drain dropped", {31'h0, if_valid}, 32'h0);
        check("drain next addr", imem_addr, 32'h0000_0400);

        // Redirect coinciding with ack discards the response.
        cycle(1, 32'h5555_5555, 1, 32'h0000_0800, 0);
        check("br+ack dropped", {31'h0, if_valid}, 32'h0);
        check("br+ack addr", imem_addr, 32'h0000_0800);

        // PC wrap.
        cycle(1, 32'h0000_0022, 0, 0, 0);
        cycle(0, 0, 1, 32'hFFFF_FFFE, 0);
        check("wrap addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1, 32'h0000_0033, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("wrap next addr", imem_addr, 32'h0000_0000);

        // Branch and of_ready together in DELIVER: branch wins.
        cycle(1, 32'h0000_0044, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0080, 1);
        check("br+rdy valid", {31'h0, if_valid}, 32'h0);
        check("br+rdy addr", imem_addr, 32'h0000_0080);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rd = $urandom;
            if (rd[31:27] == 5'b11111) rd[31] = 1'b0;
            tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            cycle($urandom_range(0, 1) == 1, rd, $urandom_range(0, 7) == 0, tg, $urandom_range(0, 2) != 0);
        end

        // Reset while a request is outstanding.
        while (!m_req()) cycle(0, 0, 0, 0, 1);
        do_reset();
        #0;
        check("post-reset req", {31'h0, imem_req}, 32'h1);
        check("post-reset addr", imem_addr, RST_PC);

        // hlt delivery.
        cycle(1, 32'hF800_0000, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
`ifdef IF_HALT_DETECT_EN
        check("hlt halted", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h0, 1, 32'h0000_0300, 0);
            check("hlt no req", {31'h0, imem_req}, 32'h0);
        end
        do_reset();
        cycle(0, 0, 0, 0, 0);
        check("hlt reset addr", imem_addr, RST_PC);
`else
        check("hlt plain halted", {31'h0, halted}, 32'h0);
        check("hlt plain addr", imem_addr, RST_PC + 32'd4);
        cycle(1, 32'h0000_0055, 0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction memory request, held until acknowledged.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, stable while imem_req high.
REQ-006 SHALL have port imem_rdata  input  32  fetched instruction, valid when imem_ack high.
REQ-007 SHALL have port imem_ack  input  1  one-cycle completion of the current request.
REQ-008 SHALL have port branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-009 SHALL have port branch_target  input  32  redirect PC, sampled when branch_taken high.
REQ-010 SHALL have port of_ready  input  1  operand-fetch stage accepts the current instruction.
REQ-011 SHALL have port if_valid  output  1  if_pc/if_instruction valid for operand fetch.
REQ-012 SHALL have port if_pc  output  32  PC of the delivered instruction.
REQ-013 SHALL have port if_instruction  output  32  delivered instruction word.
REQ-014 SHALL have port halted  output  1  fetch stopped by hlt (see Configuration).

Function
REQ-015 SHALL implement FSM states FETCH, DELIVER, DRAIN, HALTED; all outputs registered.
REQ-016 FETCH: SHALL drive imem_req=1, imem_addr=pc; on imem_ack, SHALL register if_instruction=imem_rdata, if_pc=pc, if_valid=1 next cycle, pc<=pc+4, state->DELIVER.
REQ-017 DELIVER: SHALL hold imem_req=0 and if_valid/if_pc/if_instruction stable until of_ready; on of_ready, SHALL clear if_valid next cycle and go to FETCH.
REQ-018 Minimum latency: request to if_valid = ack cycle + 1; throughput at most one instruction per two cycles.
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 branch_taken SHALL load pc with {branch_target[31:2],2'b00}; low two bits always forced zero.
REQ-021 branch_taken in DELIVER SHALL clear if_valid next cycle and go to FETCH, overriding simultaneous of_ready.
REQ-022 branch_taken in FETCH with imem_ack same cycle SHALL discard imem_rdata (no if_valid) and go to FETCH at new pc.
REQ-023 branch_taken in FETCH without imem_ack SHALL go to DRAIN: imem_req and old imem_addr held until imem_ack, response discarded, then FETCH at new pc.
REQ-024 branch_taken in DRAIN SHALL update pc to latest target and remain in DRAIN.
REQ-025 if_valid SHALL never assert for an instruction fetched before the latest redirect.

Reset
REQ-026 On reset SHALL set pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_instruction=0, halted=0; imem_req=1 from the first cycle after reset deasserts.
REQ-027 Reset mid-request SHALL abandon the outstanding request; the memory is reset by the same signal and issues no stale ack.
REQ-028 reset SHALL take priority over branch_taken, imem_ack and of_ready.

Configuration
REQ-029 Macro IF_HALT_DETECT_EN defined: when a delivered instruction with opcode if_instruction[31:27]=5'b11111 (hlt) is accepted, SHALL enter HALTED: imem_req=0, if_valid=0, halted=1, leaving only via reset; branch_taken ignored in HALTED.
REQ-030 Macro IF_HALT_DETECT_EN undefined: HALTED unreachable, halted tied 0, hlt delivered like any instruction.

Verification
REQ-031 Reset, RESET_PC=32'h100, ack 1 cycle after every req, of_ready=1 -> imem_addr 0x100,0x104,0x108; if_pc matches each, if_instruction equals rdata.
REQ-032 Deliver 32'h1234_5678 with of_ready=0 for 5 cycles -> if_valid, if_pc, if_instruction stable, imem_req=0; of_ready=1 -> next fetch at pc+4.
REQ-033 Request to 0x200 pending, branch_taken with target 0x403 -> imem_addr holds 0x200 until ack, response dropped, next request at 0x400.
REQ-034 pc=32'hFFFF_FFFC fetched and accepted -> next imem_addr=32'h0000_0000.
REQ-035 DELIVER with branch_taken and of_ready same cycle, target 0x80 -> if_valid low next cycle, next request 0x80.
REQ-036 IF_HALT_DETECT_EN: deliver 32'hF800_0000, accept -> halted=1, no further imem_req; branch_taken ignored; reset restores fetch at RESET_PC.
